// File: rtl/cpu_defs.sv
// Shared definitions for the fetch front end.
// NOP encoding, IF state enum and default reset PC.
package cpu_defs;

  localparam logic [31:0] INST_NOP     = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic {
    IF_BOOT = 1'b0,
    IF_RUN  = 1'b1
  } if_state_e;

endpackage

// File: rtl/if_stage_if.sv
// Instruction ROM bus between IF and a synchronous-read ROM.
// master: drives word address, receives data one cycle later.
interface if_stage_if #(
  parameter int ADDR_W = 14
);

  logic [ADDR_W-1:0] irom_addr;
  logic [31:0]       irom_inst;

  modport master (
    output irom_addr,
    input  irom_inst
  );

  modport slave (
    input  irom_addr,
    output irom_inst
  );

endinterface

// File: rtl/perf_counter.sv
// Saturating event counter, synchronous active-high reset.
// Ports: clk, rst_n (1 = reset), inc, count.
module perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage with IF/ID register and debug counters.
// Ports: clk, rst_n (active-high sync), stop/flush/target from ID,
// irom (ROM bus master), if_id_* to ID, cnt_* perf counters.
module if_stage
  import cpu_defs::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter int          ADDR_W     = 14,
  parameter int          BOOT_DELAY = 2,
  parameter int          CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pipeline_stop,
  input  logic             pipeline_flush,
  input  logic [31:0]      jump_target,
  if_stage_if.master       irom,
  output logic [31:0]      if_id_pc,
  output logic [31:0]      if_id_pc4,
  output logic [31:0]      if_id_inst,
  output logic             if_id_valid,
  output logic [CNT_W-1:0] cnt_fetch,
  output logic [CNT_W-1:0] cnt_stall,
  output logic [CNT_W-1:0] cnt_flush
);

  localparam int BW = $clog2(BOOT_DELAY + 1);

  if_state_e   state_q, state_d;
  logic [BW-1:0] boot_q, boot_d;
  logic [31:0] pc_q, npc;
  logic [ADDR_W-1:0] addr_c;

  logic [31:0] id_pc_d, id_pc4_d, id_inst_d;
  logic        id_valid_d;

  logic inc_fetch, inc_stall, inc_flush;

  // Target low bits are forced to zero, never consumed.
  logic unused_tgt;
  assign unused_tgt = ^jump_target[1:0];

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q     <= IF_BOOT;
      boot_q      <= '0;
      pc_q        <= RESET_PC;
      if_id_pc    <= '0;
      if_id_pc4   <= 32'h4;
      if_id_inst  <= INST_NOP;
      if_id_valid <= 1'b0;
    end else begin
      state_q     <= state_d;
      boot_q      <= boot_d;
      pc_q        <= npc;
      if_id_pc    <= id_pc_d;
      if_id_pc4   <= id_pc4_d;
      if_id_inst  <= id_inst_d;
      if_id_valid <= id_valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    boot_d     = boot_q;
    npc        = pc_q;
    addr_c     = RESET_PC[ADDR_W+1:2];
    id_pc_d    = if_id_pc;
    id_pc4_d   = if_id_pc4;
    id_inst_d  = if_id_inst;
    id_valid_d = if_id_valid;
    inc_fetch  = 1'b0;
    inc_stall  = 1'b0;
    inc_flush  = 1'b0;

    unique case (state_q)
      IF_BOOT: begin
        boot_d     = boot_q + 1'b1;
        id_inst_d  = INST_NOP;
        id_valid_d = 1'b0;
        if (boot_q == BW'(BOOT_DELAY - 1)) begin
          state_d = IF_RUN;
        end
      end
      IF_RUN: begin
        // ROM data at this cycle belongs to pc_q; addr
        // follows npc so the next word is ready on time.
        unique case (1'b1)
          pipeline_flush: begin
            npc        = {jump_target[31:2], 2'b00};
            id_inst_d  = INST_NOP;
            id_valid_d = 1'b0;
            inc_flush  = 1'b1;
          end
          (pipeline_stop && !pipeline_flush): begin
            npc       = pc_q;
            inc_stall = 1'b1;
          end
          default: begin
            npc        = pc_q + 32'd4;
            id_pc_d    = pc_q;
            id_pc4_d   = pc_q + 32'd4;
            id_inst_d  = irom.irom_inst;
            id_valid_d = 1'b1;
            inc_fetch  = 1'b1;
          end
        endcase
        addr_c = npc[ADDR_W+1:2];
      end
      default: begin
        state_d = IF_BOOT;
      end
    endcase
  end

  assign irom.irom_addr = addr_c;

  perf_counter #(.CNT_W(CNT_W)) u_cnt_fetch (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (inc_fetch),
    .count (cnt_fetch)
  );

  perf_counter #(.CNT_W(CNT_W)) u_cnt_stall (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (inc_stall),
    .count (cnt_stall)
  );

  perf_counter #(.CNT_W(CNT_W)) u_cnt_flush (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (inc_flush),
    .count (cnt_flush)
  );

endmodule

// File: tb/tb_if_stage.sv
// Testbench for if_stage: directed vector table plus
// randomized stop/flush/reset against a behavioural model.
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int BOOT = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        stop = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] tgt = '0;

  logic [31:0] id_pc, id_pc4, id_inst;
  logic        id_vld;
  logic [31:0] c_fetch, c_stall, c_flush;

  logic [31:0] id_pc2, id_pc42, id_inst2;
  logic        id_vld2;
  logic [1:0]  c2_fetch, c2_stall, c2_flush;

  if_stage_if #(.ADDR_W(14)) bus ();
  if_stage_if #(.ADDR_W(14)) bus2 ();

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(logic [13:0] a);
    return {a[7:0], ~a[13:6], a, 2'b11};
  endfunction

  always @(posedge clk) bus.irom_inst <= rom_word(bus.irom_addr);
  always @(posedge clk) bus2.irom_inst <= rom_word(bus2.irom_addr);

  if_stage #(
    .RESET_PC(32'h0), .ADDR_W(14), .BOOT_DELAY(BOOT), .CNT_W(32)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .pipeline_stop(stop), .pipeline_flush(flush),
    .jump_target(tgt), .irom(bus.master),
    .if_id_pc(id_pc), .if_id_pc4(id_pc4),
    .if_id_inst(id_inst), .if_id_valid(id_vld),
    .cnt_fetch(c_fetch), .cnt_stall(c_stall),
    .cnt_flush(c_flush)
  );

  // Narrow counters to exercise saturation.
  if_stage #(
    .RESET_PC(32'h0), .ADDR_W(14), .BOOT_DELAY(BOOT), .CNT_W(2)
  ) dut2 (
    .clk(clk), .rst_n(rst_n),
    .pipeline_stop(stop), .pipeline_flush(flush),
    .jump_target(tgt), .irom(bus2.master),
    .if_id_pc(id_pc2), .if_id_pc4(id_pc42),
    .if_id_inst(id_inst2), .if_id_valid(id_vld2),
    .cnt_fetch(c2_fetch), .cnt_stall(c2_stall),
    .cnt_flush(c2_flush)
  );

  int n_tests = 0;
  int n_fail = 0;

  // Behavioural model: what ID should see.
  int          m_boot = BOOT;
  logic [31:0] m_pc = 32'h0;
  logic        m_vld = 1'b0;
  logic [31:0] m_idpc = 32'h0;
  logic [31:0] m_inst = NOP;
  int          m_fetch = 0, m_stall = 0, m_flush = 0;

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int sat3(int x);
    return (x > 3) ? 3 : x;
  endfunction

  task automatic model_edge(logic r, logic s, logic f,
                            logic [31:0] t);
    if (r) begin
      m_boot = BOOT; m_pc = 32'h0; m_vld = 1'b0;
      m_inst = NOP; m_fetch = 0; m_stall = 0; m_flush = 0;
    end else if (m_boot > 0) begin
      m_boot--; m_vld = 1'b0; m_inst = NOP;
    end else if (f) begin
      m_vld = 1'b0; m_inst = NOP; m_pc = t & ~32'h3;
      m_flush++;
    end else if (s) begin
      m_stall++;
    end else begin
      m_idpc = m_pc; m_inst = rom_word(m_pc[15:2]);
      m_vld = 1'b1; m_pc = m_pc + 32'd4; m_fetch++;
    end
  endtask

  // Called right after a falling edge.
  task automatic step(logic r, logic s, logic f,
                      logic [31:0] t);
    logic [31:0] ea;
    rst_n = r; stop = s; flush = f; tgt = t;
    #1;
    if (!r) begin
      if (m_boot > 0) ea = 32'h0;
      else if (f) ea = t;
      else if (s) ea = m_pc;
      else ea = m_pc + 32'd4;
      chk("irom_addr", 32'(bus.irom_addr), 32'(ea[15:2]));
    end
    @(posedge clk);
    model_edge(r, s, f, t);
    @(negedge clk);
    chk("valid", 32'(id_vld), 32'(m_vld));
    if (m_vld) begin
      chk("pc", id_pc, m_idpc);
      chk("pc4", id_pc4, m_idpc + 32'd4);
    end
    chk("inst", id_inst, m_inst);
    chk("cnt_fetch", c_fetch, 32'(m_fetch));
    chk("cnt_stall", c_stall, 32'(m_stall));
    chk("cnt_flush", c_flush, 32'(m_flush));
    chk("sat_fetch", 32'(c2_fetch), 32'(sat3(m_fetch)));
    chk("sat_stall", 32'(c2_stall), 32'(sat3(m_stall)));
    chk("sat_flush", 32'(c2_flush), 32'(sat3(m_flush)));
  endtask

  typedef struct {
    logic        rst, stop, flush;
    logic [31:0] tgt;
    logic        vld;
    logic [31:0] pc;
    int          fch, stl, fls;
  } vec_t;

  function automatic vec_t mk(logic r, logic s, logic f,
                              logic [31:0] t, logic v,
                              logic [31:0] p, int a, int b,
                              int c);
    vec_t x;
    x.rst = r; x.stop = s; x.flush = f; x.tgt = t;
    x.vld = v; x.pc = p; x.fch = a; x.stl = b; x.fls = c;
    return x;
  endfunction

  vec_t tbl[$];

  initial begin
    tbl.push_back(mk(1,0,0,0,      0,0,      0,0,0));
    tbl.push_back(mk(1,0,0,0,      0,0,      0,0,0));
    tbl.push_back(mk(1,0,0,0,      0,0,      0,0,0));
    tbl.push_back(mk(0,0,0,0,      0,0,      0,0,0));
    tbl.push_back(mk(0,0,0,0,      0,0,      0,0,0));
    tbl.push_back(mk(0,0,0,0,      1,'h0,    1,0,0));
    tbl.push_back(mk(0,0,0,0,      1,'h4,    2,0,0));
    tbl.push_back(mk(0,0,0,0,      1,'h8,    3,0,0));
    tbl.push_back(mk(0,1,0,0,      1,'h8,    3,1,0));
    tbl.push_back(mk(0,1,0,0,      1,'h8,    3,2,0));
    tbl.push_back(mk(0,1,0,0,      1,'h8,    3,3,0));
    tbl.push_back(mk(0,0,0,0,      1,'hC,    4,3,0));
    tbl.push_back(mk(0,0,0,0,      1,'h10,   5,3,0));
    tbl.push_back(mk(0,0,1,'h100,  0,0,      5,3,1));
    tbl.push_back(mk(0,0,0,0,      1,'h100,  6,3,1));
    tbl.push_back(mk(0,0,0,0,      1,'h104,  7,3,1));
    tbl.push_back(mk(0,1,1,'h40,   0,0,      7,3,2));
    tbl.push_back(mk(0,0,0,0,      1,'h40,   8,3,2));
    tbl.push_back(mk(0,0,1,'h103,  0,0,      8,3,3));
    tbl.push_back(mk(0,0,0,0,      1,'h100,  9,3,3));
    tbl.push_back(mk(0,0,1,'h18,   0,0,      9,3,4));
    tbl.push_back(mk(0,0,0,0,      1,'h18,  10,3,4));
    tbl.push_back(mk(0,0,0,0,      1,'h1C,  11,3,4));
    tbl.push_back(mk(0,0,0,0,      1,'h20,  12,3,4));
    tbl.push_back(mk(0,1,0,0,      1,'h20,  12,4,4));
    tbl.push_back(mk(1,1,0,0,      0,0,      0,0,0));
    tbl.push_back(mk(0,0,0,0,      0,0,      0,0,0));
    tbl.push_back(mk(0,0,0,0,      0,0,      0,0,0));
    tbl.push_back(mk(0,0,0,0,      1,'h0,    1,0,0));
    tbl.push_back(mk(0,0,0,0,      1,'h4,    2,0,0));

    @(negedge clk);
    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].stop, tbl[i].flush, tbl[i].tgt);
      chk($sformatf("tbl%0d_valid", i), 32'(id_vld),
          32'(tbl[i].vld));
      if (tbl[i].vld) begin
        chk($sformatf("tbl%0d_pc", i), id_pc, tbl[i].pc);
        chk($sformatf("tbl%0d_inst", i), id_inst,
            rom_word(tbl[i].pc[15:2]));
      end else begin
        chk($sformatf("tbl%0d_nop", i), id_inst, NOP);
      end
      chk($sformatf("tbl%0d_fetch", i), c_fetch,
          32'(tbl[i].fch));
      chk($sformatf("tbl%0d_stall", i), c_stall,
          32'(tbl[i].stl));
      chk($sformatf("tbl%0d_flush", i), c_flush,
          32'(tbl[i].fls));
    end

    for (int n = 0; n < 600; n++) begin
      logic        r, s, f;
      logic [31:0] t;
      r = ($urandom_range(0, 99) == 0);
      s = ($urandom_range(0, 99) < 30);
      f = ($urandom_range(0, 99) < 15);
      t = $urandom;
      step(r, s, f, t);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
